interface_timer: RTL

INTERFACE_TIMER -- requirements
Module: interface_timer

---
 rtl/interface_timer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/interface_timer.sv
// Memory-mapped down-counting timer with a 16-bit prescaler, one-shot or
// auto-reload operation and a level interrupt gated by CTRL.IE.
module interface_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  o_dbg_state
);
    // Bus handshake: a write completes on every rising clk edge where wen=1;
    // there is no wait state. Reads are combinational from addr.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [9:0] A_CTRL   = 10'h000;
    localparam logic [9:0] A_PRESC  = 10'h001;
    localparam logic [9:0] A_LOAD   = 10'h002;
    localparam logic [9:0] A_COUNT  = 10'h003;
    localparam logic [9:0] A_STATUS = 10'h004;

    state_t      r_state;
    logic        r_en;
    logic        r_auto;
    logic        r_ie;
    logic        r_done;
    logic [15:0] r_presc;
    logic [15:0] r_pcnt;
    logic [31:0] r_load;
    logic [31:0] r_count;

    logic [9:0]  w_word;
    logic        w_wr_ctrl;
    logic        w_wr_presc;
    logic        w_wr_load;
    logic        w_wr_status;
    logic        w_tick;
    logic        w_auto_next;
    logic        w_done_set;

    assign w_word      = addr[11:2];
    assign w_wr_ctrl   = wen && (w_word == A_CTRL);
    assign w_wr_presc  = wen && (w_word == A_PRESC);
    assign w_wr_load   = wen && (w_word == A_LOAD);
    assign w_wr_status = wen && (w_word == A_STATUS);
    assign w_tick      = (r_state == ST_RUN) && (r_pcnt == r_presc);

    // A CTRL write in RUN wins over the tick: the freshly written AUTO decides
    // reload vs. stop, and a disable suppresses the expiry altogether.
    assign w_auto_next = w_wr_ctrl ? wdata[1] : r_auto;
    assign w_done_set  = w_tick && (r_count == 32'd0) && !(w_wr_ctrl && !wdata[0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_auto  <= 1'b0;
            r_ie    <= 1'b0;
            r_done  <= 1'b0;
            r_presc <= 16'd0;
            r_pcnt  <= 16'd0;
            r_load  <= 32'd0;
            r_count <= 32'd0;
        end else begin
            if (w_wr_presc) r_presc <= wdata[15:0];
            if (w_wr_load)  r_load  <= wdata;

            if (w_done_set)                   r_done <= 1'b1;
            else if (w_wr_status && wdata[0]) r_done <= 1'b0;

            if (w_wr_ctrl) begin
                r_auto <= wdata[1];
                r_ie   <= wdata[2];
            end

            if (w_wr_ctrl && !wdata[0]) begin
                r_state <= ST_IDLE;
                r_en    <= 1'b0;
            end else if (w_wr_ctrl && (r_state != ST_RUN)) begin
                r_state <= ST_RUN;
                r_en    <= 1'b1;
                r_count <= r_load;
                r_pcnt  <= 16'd0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_tick) begin
                            r_pcnt <= 16'd0;
                            if (r_count != 32'd0) begin
                                r_count <= r_count - 32'd1;
                            end else if (w_auto_next) begin
                                r_count <= r_load;
                            end else begin
                                r_state <= ST_EXPIRED;
                                r_en    <= 1'b0;
                            end
                        end else begin
                            r_pcnt <= r_pcnt + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (w_word)
            A_CTRL:   rdata = {29'd0, r_ie, r_auto, r_en};
            A_PRESC:  rdata = {16'd0, r_presc};
            A_LOAD:   rdata = r_load;
            A_COUNT:  rdata = r_count;
            A_STATUS: rdata = {31'd0, r_done};
            default:  rdata = 32'd0;
        endcase
    end

    assign irq         = r_done & r_ie;
    assign o_dbg_state = r_state;

endmodule
